// File: rtl/cop0_pkg.sv
// CP0 shared types: Cause/Status/EBase layouts, register keys,
// ExcCodes, write masks and reset values.
package cop0_pkg;

  typedef struct packed {
    logic       bd;
    logic       ti;
    logic [5:0] rsv_29_24;
    logic       iv;
    logic [6:0] rsv_22_16;
    logic [7:0] ip;
    logic       rsv_7;
    logic [4:0] exc_code;
    logic [1:0] rsv_1_0;
  } cause_t;

  typedef struct packed {
    logic [3:0] cu;
    logic [4:0] rsv_27_23;
    logic       bev;
    logic [5:0] rsv_21_16;
    logic [7:0] im;
    logic [2:0] rsv_7_5;
    logic       um;
    logic       rsv_3;
    logic       erl;
    logic       exl;
    logic       ie;
  } status_t;

  typedef struct packed {
    logic        one;
    logic        zero;
    logic [17:0] base;
    logic [1:0]  rsv_11_10;
    logic [9:0]  cpu_num;
  } ebase_t;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_EBASE    = 5'd15;

  // {reg, sel} lookup keys
  localparam logic [7:0] K_BADVADDR = {REG_BADVADDR, 3'd0};
  localparam logic [7:0] K_COUNT    = {REG_COUNT, 3'd0};
  localparam logic [7:0] K_COMPARE  = {REG_COMPARE, 3'd0};
  localparam logic [7:0] K_STATUS   = {REG_STATUS, 3'd0};
  localparam logic [7:0] K_CAUSE    = {REG_CAUSE, 3'd0};
  localparam logic [7:0] K_EPC      = {REG_EPC, 3'd0};
  localparam logic [7:0] K_PRID     = {REG_PRID, 3'd0};
  localparam logic [7:0] K_EBASE    = {REG_EBASE, 3'd1};

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_CPU  = 5'd11;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] STATUS_WMASK = 32'hF040_FF17;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0080_0300;
  localparam logic [31:0] EBASE_WMASK  = 32'h3FFF_F000;

  localparam logic [31:0] STATUS_RST = 32'h0040_0004;
  localparam logic [31:0] EBASE_RST  = 32'h8000_0000;

  localparam logic [31:0] VEC_BEV_BASE = 32'hBFC0_0200;
  localparam logic [31:0] VEC_OFF_GEN  = 32'h0000_0180;
  localparam logic [31:0] VEC_OFF_INT  = 32'h0000_0200;

  function automatic logic [31:0] wmask(
    logic [31:0] old_v,
    logic [31:0] new_v,
    logic [31:0] m
  );
    return (old_v & ~m) | (new_v & m);
  endfunction

endpackage

// File: rtl/cop0_timer.sv
// Count/Compare timer: Count ticks every other cycle, TI latches
// on an increment that lands on Compare; ports: load/clear strobes, state out.
module cop0_timer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        count_ld,
  input  logic        compare_ld,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic        phase_q;
  logic [31:0] count_inc;
  logic        hit;

  assign count_inc = count + 32'd1;
  assign hit = phase_q & ~count_ld
             & (count_inc == compare);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count   <= '0;
      compare <= '0;
      phase_q <= 1'b0;
      ti      <= 1'b0;
    end else begin
      if (count_ld) begin
        count   <= wdata;
        phase_q <= 1'b0;
      end else begin
        phase_q <= ~phase_q;
        if (phase_q) count <= count_inc;
      end
      if (compare_ld) compare <= wdata;
      // a Compare write clears TI even on a match
      if (compare_ld)  ti <= 1'b0;
      else if (hit)    ti <= 1'b1;
    end
  end

endmodule

// File: rtl/cop0_regfile.sv
// CP0 register file: mfc0/mtc0 access, exception/eret commit,
// interrupt request, exception vector, EPC and Status outputs.
module cop0_regfile
  import cop0_pkg::*;
#(
  parameter logic [31:0] PRID    = 32'h0001_9300,
  parameter logic [9:0]  CPU_NUM = 10'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  rd_addr,
  input  logic [2:0]  rd_sel,
  output logic [31:0] rd_data,
  input  logic        we,
  input  logic [4:0]  wr_addr,
  input  logic [2:0]  wr_sel,
  input  logic [31:0] wr_data,
  input  logic [5:0]  hw_int,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic        exc_badvaddr_valid,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret,
  output logic        int_req,
  output logic [31:0] exc_vector,
  output logic [31:0] epc_out,
  output logic [31:0] status_out
);

  status_t     status_q;
  cause_t      cause_q;
  ebase_t      ebase_q;
  logic [31:0] epc_q;
  logic [31:0] badvaddr_q;
  logic [5:0]  hw_q;

  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;

  logic        wr_en;
  logic [7:0]  wr_key;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;
  logic        wr_ebase;

  cause_t      cause;
  logic [31:0] vec_base;
  logic [31:0] vec_off;

  // an exception commit drops any mtc0 in the same cycle
  assign wr_en  = we & ~exc_valid;
  assign wr_key = {wr_addr, wr_sel};

  assign wr_count   = wr_en & (wr_key == K_COUNT);
  assign wr_compare = wr_en & (wr_key == K_COMPARE);
  assign wr_status  = wr_en & (wr_key == K_STATUS);
  assign wr_cause   = wr_en & (wr_key == K_CAUSE);
  assign wr_epc     = wr_en & (wr_key == K_EPC);
  assign wr_ebase   = wr_en & (wr_key == K_EBASE);

  cop0_timer u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .count_ld   (wr_count),
    .compare_ld (wr_compare),
    .wdata      (wr_data),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      status_q   <= status_t'(STATUS_RST);
      cause_q    <= '0;
      ebase_q    <= ebase_t'(EBASE_RST | {22'd0, CPU_NUM});
      epc_q      <= '0;
      badvaddr_q <= '0;
      hw_q       <= '0;
    end else begin
      hw_q <= hw_int;
      if (exc_valid) begin
        if (!status_q.exl) begin
          epc_q      <= exc_bd ? exc_pc - 32'd4 : exc_pc;
          cause_q.bd <= exc_bd;
        end
        cause_q.exc_code <= exc_code;
        status_q.exl     <= 1'b1;
        if (exc_badvaddr_valid) badvaddr_q <= exc_badvaddr;
      end else begin
        if (wr_status)
          status_q <= status_t'(wmask(status_q, wr_data, STATUS_WMASK));
        if (wr_cause)
          cause_q <= cause_t'(wmask(cause_q, wr_data, CAUSE_WMASK));
        if (wr_epc)
          epc_q <= wr_data;
        if (wr_ebase)
          ebase_q <= ebase_t'(wmask(ebase_q, wr_data, EBASE_WMASK));
        // later assignment overrides a same-cycle Status write
        if (eret) begin
          if (status_q.erl) status_q.erl <= 1'b0;
          else              status_q.exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    cause          = cause_q;
    cause.ti       = ti;
    cause.ip[7]    = hw_q[5] | ti;
    cause.ip[6:2]  = hw_q[4:0];
  end

  always_comb begin
    rd_data = '0;
    case ({rd_addr, rd_sel})
      K_BADVADDR: rd_data = badvaddr_q;
      K_COUNT:    rd_data = count;
      K_COMPARE:  rd_data = compare;
      K_STATUS:   rd_data = status_q;
      K_CAUSE:    rd_data = cause;
      K_EPC:      rd_data = epc_q;
      K_PRID:     rd_data = PRID;
      K_EBASE:    rd_data = ebase_q;
      default:    rd_data = '0;
    endcase
  end

  always_comb begin
    vec_base = status_q.bev ? VEC_BEV_BASE
             : {2'b10, ebase_q.base, 12'h000};
    vec_off  = VEC_OFF_GEN;
    if (exc_code == EXC_INT && cause_q.iv && !status_q.exl)
      vec_off = VEC_OFF_INT;
  end

  assign exc_vector = vec_base + vec_off;
  assign int_req    = status_q.ie & ~status_q.exl & ~status_q.erl
                    & |(cause.ip & status_q.im);
  assign epc_out    = epc_q;
  assign status_out = status_q;

endmodule

// File: tb/tb_cop0_regfile.sv
// Self-checking bench for cop0_regfile: write/readback table,
// directed corner sequences, and random traffic against a model.
module tb_cop0_regfile;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [4:0]  rd_addr;
  logic [2:0]  rd_sel;
  logic [31:0] rd_data;
  logic        we;
  logic [4:0]  wr_addr;
  logic [2:0]  wr_sel;
  logic [31:0] wr_data;
  logic [5:0]  hw_int;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        exc_badvaddr_valid;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic        int_req;
  logic [31:0] exc_vector;
  logic [31:0] epc_out;
  logic [31:0] status_out;

  cop0_regfile dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .rd_addr            (rd_addr),
    .rd_sel             (rd_sel),
    .rd_data            (rd_data),
    .we                 (we),
    .wr_addr            (wr_addr),
    .wr_sel             (wr_sel),
    .wr_data            (wr_data),
    .hw_int             (hw_int),
    .exc_valid          (exc_valid),
    .exc_code           (exc_code),
    .exc_pc             (exc_pc),
    .exc_bd             (exc_bd),
    .exc_badvaddr_valid (exc_badvaddr_valid),
    .exc_badvaddr       (exc_badvaddr),
    .eret               (eret),
    .int_req            (int_req),
    .exc_vector         (exc_vector),
    .epc_out            (epc_out),
    .status_out         (status_out)
  );

  // {reg, sel} keys
  localparam logic [7:0] KBAD = 8'h40;
  localparam logic [7:0] KCNT = 8'h48;
  localparam logic [7:0] KCMP = 8'h58;
  localparam logic [7:0] KST  = 8'h60;
  localparam logic [7:0] KCA  = 8'h68;
  localparam logic [7:0] KEPC = 8'h70;
  localparam logic [7:0] KPR  = 8'h78;
  localparam logic [7:0] KEB  = 8'h79;

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  logic [31:0] m_status, m_cause, m_epc, m_bad;
  logic [31:0] m_cmp, m_ebase, m_load;
  int unsigned m_age;
  logic        m_ti;

  typedef struct {
    logic [7:0]  k;
    logic [31:0] wd;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t       tbl [13];
  logic [7:0] wkeys [10];
  logic [4:0] codes [8];

  function automatic logic [31:0] m_count();
    return m_load + 32'(m_age >> 1);
  endfunction

  function automatic logic [31:0] m_cause_rd();
    logic [31:0] c;
    c = m_cause;
    if (m_ti) c = c | 32'h4000_8000;
    return c;
  endfunction

  function automatic logic [31:0] m_read(logic [7:0] k);
    case (k)
      KBAD:    return m_bad;
      KCNT:    return m_count();
      KCMP:    return m_cmp;
      KST:     return m_status;
      KCA:     return m_cause_rd();
      KEPC:    return m_epc;
      KPR:     return 32'h0001_9300;
      KEB:     return m_ebase;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_int();
    logic [31:0] c;
    c = m_cause_rd();
    return m_status[0] && !m_status[1] && !m_status[2]
        && ((c[15:8] & m_status[15:8]) != 8'h0);
  endfunction

  function automatic logic [31:0] m_vec();
    logic [31:0] b;
    logic [31:0] o;
    if (m_status[22]) b = 32'hBFC0_0200;
    else b = 32'h8000_0000 | (m_ebase & 32'h3FFF_F000);
    o = 32'h180;
    if (exc_code == 5'd0 && m_cause[23] && !m_status[1]) o = 32'h200;
    return b + o;
  endfunction

  task automatic model_edge();
    logic [7:0]  k;
    logic [31:0] oc, nc;
    logic        wen, erl0, cld;
    if (!reset_n) begin
      m_status = 32'h0040_0004;
      m_cause = 0; m_epc = 0; m_bad = 0;
      m_cmp = 0; m_ebase = 32'h8000_0000;
      m_load = 0; m_age = 0; m_ti = 0;
      return;
    end
    k = {wr_addr, wr_sel};
    wen = we && !exc_valid;
    erl0 = m_status[2];
    cld = wen && k == KCNT;
    oc = m_count();
    if (cld) begin m_load = wr_data; m_age = 0; end
    else m_age++;
    nc = m_count();
    if (wen && k == KCMP) m_ti = 0;
    else if (!cld && nc != oc && nc == m_cmp) m_ti = 1;
    if (wen && k == KCMP) m_cmp = wr_data;
    m_cause[15:10] = hw_int;
    if (exc_valid) begin
      if (!m_status[1]) begin
        m_epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
        m_cause[31] = exc_bd;
      end
      m_cause[6:2] = exc_code;
      m_status[1] = 1'b1;
      if (exc_badvaddr_valid) m_bad = exc_badvaddr;
    end else begin
      if (wen) begin
        case (k)
          KST:  m_status = (m_status & ~32'hF040_FF17)
                         | (wr_data & 32'hF040_FF17);
          KCA:  m_cause = (m_cause & ~32'h0080_0300)
                        | (wr_data & 32'h0080_0300);
          KEPC: m_epc = wr_data;
          KEB:  m_ebase = (m_ebase & ~32'h3FFF_F000)
                        | (wr_data & 32'h3FFF_F000);
          default: ;
        endcase
      end
      if (eret) begin
        if (erl0) m_status[2] = 1'b0;
        else      m_status[1] = 1'b0;
      end
    end
  endtask

  always @(posedge clk) model_edge();

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    we = 0; exc_valid = 0; eret = 0;
    exc_badvaddr_valid = 0; exc_bd = 0; hw_int = 0;
    exc_code = 0; exc_pc = 0; exc_badvaddr = 0;
    wr_addr = 0; wr_sel = 0; wr_data = 0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 0;
    tick();
    reset_n = 1;
  endtask

  task automatic mtc0(input logic [7:0] k, input logic [31:0] d);
    {wr_addr, wr_sel} = k;
    wr_data = d;
    we = 1;
    tick();
    we = 0;
  endtask

  task automatic rd(input logic [7:0] k);
    {rd_addr, rd_sel} = k;
    #1;
  endtask

  initial begin
    int first;
    int idx;
    rd_addr = 0; rd_sel = 0;
    idle();
    reset_n = 0;
    tick();
    tick();
    reset_n = 1;

    // reset state
    rd(KST); chk("rst_status", rd_data, 32'h0040_0004);
    rd(KPR); chk("rst_prid", rd_data, 32'h0001_9300);
    rd(KEB); chk("rst_ebase", rd_data, 32'h8000_0000);
    chk("rst_int_req", 32'(int_req), 32'd0);
    chk("rst_epc_out", epc_out, 32'd0);
    chk("rst_status_out", status_out, 32'h0040_0004);

    // write / readback table
    tbl[0]  = '{KST,   32'hFFFF_FFFF, 32'hF040_FF17, "st_all1"};
    tbl[1]  = '{KST,   32'h0040_0004, 32'h0040_0004, "st_restore"};
    tbl[2]  = '{KCA,   32'hFFFF_FFFF, 32'h0080_0300, "cause_all1"};
    tbl[3]  = '{KCA,   32'h0000_0000, 32'h0000_0000, "cause_zero"};
    tbl[4]  = '{KEPC,  32'hDEAD_BEEF, 32'hDEAD_BEEF, "epc"};
    tbl[5]  = '{KCMP,  32'h1234_5678, 32'h1234_5678, "compare"};
    tbl[6]  = '{KEB,   32'hFFFF_FFFF, 32'hBFFF_F000, "ebase_all1"};
    tbl[7]  = '{KEB,   32'h0000_0000, 32'h8000_0000, "ebase_zero"};
    tbl[8]  = '{KBAD,  32'hFFFF_FFFF, 32'h0000_0000, "badvaddr_ro"};
    tbl[9]  = '{KPR,   32'h0000_0000, 32'h0001_9300, "prid_ro"};
    tbl[10] = '{8'h18, 32'hFFFF_FFFF, 32'h0000_0000, "unimpl_3_0"};
    tbl[11] = '{8'h61, 32'hFFFF_FFFF, 32'h0000_0000, "unimpl_12_1"};
    tbl[12] = '{KCNT,  32'h0000_1000, 32'h0000_1000, "count_load"};
    for (int i = 0; i < 13; i++) begin
      mtc0(tbl[i].k, tbl[i].wd);
      rd(tbl[i].k);
      chk(tbl[i].nm, rd_data, tbl[i].exp);
    end

    // timer interrupt
    do_reset();
    mtc0(KST, 32'h0000_8001);
    mtc0(KCMP, 32'd10);
    mtc0(KCNT, 32'd0);
    rd(KCA);
    first = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      #1;
      if (first == 0 && rd_data[30]) begin
        first = i;
        chk("ti_ip7", 32'(rd_data[15]), 32'd1);
        chk("ti_int_req", 32'(int_req), 32'd1);
      end
    end
    chk("ti_latency", 32'(first), 32'd20);
    rd(KCA); chk("ti_sticky", 32'(rd_data[30]), 32'd1);
    mtc0(KCMP, 32'h0001_0000);
    rd(KCA); chk("ti_clear", 32'(rd_data[30]), 32'd0);
    chk("ti_clear_int", 32'(int_req), 32'd0);

    // exception entry in delay slot
    do_reset();
    mtc0(KST, 32'h0);
    exc_valid = 1; exc_code = 5'd12;
    exc_pc = 32'h8000_0100; exc_bd = 1;
    #1 chk("exc_vec_gen", exc_vector, 32'h8000_0180);
    tick();
    idle();
    rd(KCA);
    chk("exc_epc", epc_out, 32'h8000_00FC);
    chk("exc_cause", rd_data, 32'h8000_0030);
    chk("exc_status", status_out, 32'h0000_0002);
    exc_valid = 1; exc_code = 5'd4; exc_pc = 32'h9000_0000;
    exc_badvaddr_valid = 1; exc_badvaddr = 32'h1234_5678;
    tick();
    idle();
    rd(KCA);
    chk("exc2_epc_hold", epc_out, 32'h8000_00FC);
    chk("exc2_cause", rd_data, 32'h8000_0010);
    rd(KBAD); chk("exc2_badvaddr", rd_data, 32'h1234_5678);

    // IV interrupt vector and eret ERL then EXL
    do_reset();
    mtc0(KCA, 32'h0080_0000);
    exc_valid = 1; exc_code = 5'd0;
    #1 chk("iv_vec", exc_vector, 32'hBFC0_0400);
    tick();
    idle();
    chk("iv_status", status_out, 32'h0040_0006);
    eret = 1; tick(); eret = 0;
    chk("eret_erl", status_out, 32'h0040_0002);
    eret = 1; tick(); eret = 0;
    chk("eret_exl", status_out, 32'h0040_0000);

    // exception beats mtc0, no read bypass, eret beats Status write
    do_reset();
    mtc0(KST, 32'h0);
    exc_valid = 1; exc_code = 5'd8; exc_pc = 32'h100;
    {wr_addr, wr_sel} = KEPC; wr_data = 32'h1234; we = 1;
    tick();
    idle();
    chk("exc_vs_we", epc_out, 32'h100);
    {wr_addr, wr_sel} = KEPC; wr_data = 32'h55; we = 1;
    rd(KEPC); chk("no_bypass", rd_data, 32'h100);
    tick();
    we = 0;
    rd(KEPC); chk("wr_visible", rd_data, 32'h55);
    {wr_addr, wr_sel} = KST; wr_data = 32'h3; we = 1; eret = 1;
    tick();
    idle();
    chk("eret_vs_we", status_out, 32'h1);
    mtc0(KCNT, 32'hFFFF_FFFF);
    rd(KCNT); chk("wrap_e0", rd_data, 32'hFFFF_FFFF);
    tick(); #1 chk("wrap_e1", rd_data, 32'hFFFF_FFFF);
    tick(); #1 chk("wrap_e2", rd_data, 32'h0);

    // random traffic against the model
    wkeys = '{KBAD, KCNT, KCMP, KST, KCA, KEPC, KPR, KEB, 8'h18, 8'h61};
    codes = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12};
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 3) == 0) hw_int = 6'($urandom);
      we = ($urandom_range(0, 4) == 0);
      idx = $urandom_range(0, 9);
      {wr_addr, wr_sel} = wkeys[idx];
      wr_data = $urandom;
      if (wkeys[idx] == KCNT && $urandom_range(0, 1) == 1)
        wr_data = m_cmp - 32'($urandom_range(0, 6));
      if (wkeys[idx] == KCMP && $urandom_range(0, 1) == 1)
        wr_data = m_count() + 32'($urandom_range(1, 8));
      exc_valid = ($urandom_range(0, 19) == 0);
      exc_code = codes[$urandom_range(0, 7)];
      exc_pc = $urandom & 32'hFFFF_FFFC;
      exc_bd = $urandom_range(0, 1) == 1;
      exc_badvaddr_valid = $urandom_range(0, 1) == 1;
      exc_badvaddr = $urandom;
      eret = ($urandom_range(0, 14) == 0);
      {rd_addr, rd_sel} = wkeys[$urandom_range(0, 9)];
      #1;
      chk($sformatf("rnd%0d_rd", i), rd_data, m_read({rd_addr, rd_sel}));
      chk($sformatf("rnd%0d_int", i), 32'(int_req), 32'(m_int()));
      chk($sformatf("rnd%0d_vec", i), exc_vector, m_vec());
      chk($sformatf("rnd%0d_epc", i), epc_out, m_epc);
      chk($sformatf("rnd%0d_st", i), status_out, m_status);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cop0_regfile.md
Name: cop0_regfile

Overview:
- CP0 register file for the core, built on the shared cause/status/ebase packed structs.
- Serves mfc0 reads and mtc0 writes, takes exception-entry and eret commits from the writeback stage, and runs the Count/Compare timer.
- Supplies interrupt request, exception vector and EPC to the fetch/redirect logic.
- Single instance inside the core, beside the GPR file.

Parameters:
- PRID, 32'h00019300, value returned for PRId (reg 15 sel 0).
- CPU_NUM, 10'd0, EBase.cpu_number, read-only.

Ports:
- clk  in  1  core clock
- reset_n  in  1  synchronous active-low reset
- rd_addr  in  5  mfc0 register number
- rd_sel  in  3  mfc0 select
- rd_data  out  32  mfc0 result, combinational from current state
- we  in  1  mtc0 write strobe
- wr_addr  in  5  mtc0 register number
- wr_sel  in  3  mtc0 select
- wr_data  in  32  mtc0 data
- hw_int  in  6  external interrupt lines, level-sensitive
- exc_valid  in  1  exception commit this cycle
- exc_code  in  5  ExcCode to record
- exc_pc  in  32  PC of faulting instruction
- exc_bd  in  1  faulting instruction in delay slot
- exc_badvaddr_valid  in  1  load BadVAddr
- exc_badvaddr  in  32  faulting address
- eret  in  1  eret commit this cycle
- int_req  out  1  interrupt to be taken
- exc_vector  out  32  handler address for the current exc_valid
- epc_out  out  32  current EPC, used as the eret target
- status_out  out  32  current Status, for CU/UM checks

Behaviour:
- Supported registers:
  - BadVAddr 8/0: read-only.
  - Count 9/0.
  - Compare 11/0.
  - Status 12/0.
  - Cause 13/0.
  - EPC 14/0.
  - PRId 15/0: read-only.
  - EBase 15/1.
- Any other addr/sel: reads return 0, writes are ignored.
- Reset values (reset_n low at a clk edge):
  - Status = 32'h0040_0004 (BEV=1, ERL=1, all else 0).
  - Cause = 0, EPC = 0, BadVAddr = 0, Count = 0, Compare = 0.
  - EBase = 32'h8000_0000 | CPU_NUM.
  - Count phase bit = 0.
  - Outputs follow the reset state: int_req=0, epc_out=0, status_out=32'h0040_0004.
- mtc0 write masks (bits outside each mask hold their value):
  - Status: CU[31:28], BEV[22], IM[15:8], UM[4], ERL[2], EXL[1], IE[0].
  - Cause: IV[23], IP[9:8].
  - EBase: base[29:12].
  - EPC, Count, Compare: all 32 bits.
- Write latency: the written value is visible to rd_data on the cycle after we.
- Same-cycle read of a register being written returns the old value; no bypass.
- Count:
  - Phase bit toggles every cycle; Count increments by 1 when phase=1.
  - Count wraps 32'hFFFF_FFFF -> 0.
  - mtc0 Count loads wr_data and clears phase; the write wins over the increment.
- Timer interrupt:
  - Cause.TI[30] sets on the cycle Count increments to a value equal to Compare.
  - TI stays set until an mtc0 to Compare, which clears it.
  - Same-cycle Compare write and match: the clear wins.
- Interrupt pending bits:
  - Cause.IP[15:10] is registered each cycle from hw_int, except IP[15] = hw_int[5] | TI.
  - IP[9:8] are software bits.
- int_req = IE & ~EXL & ~ERL & |(IP & IM), computed from registered state.
- Exception entry (exc_valid=1), applied at the clock edge:
  - If EXL=0: EPC = exc_bd ? exc_pc-4 : exc_pc, and Cause.BD = exc_bd.
  - If EXL=1: EPC and BD are unchanged.
  - ExcCode[6:2] = exc_code.
  - EXL = 1.
  - BadVAddr = exc_badvaddr when exc_badvaddr_valid.
- exc_vector, combinational:
  - Base = BEV ? 32'hBFC0_0200 : {2'b10, EBase.base, 12'h000}.
  - Offset = 0x200 if exc_code==0 (Int), IV=1 and EXL=0; else 0x180.
- eret, applied at the clock edge: if ERL=1, clear ERL; otherwise clear EXL.
- Simultaneous events:
  - exc_valid with eret: exception wins, eret ignored.
  - exc_valid with we: exception wins, the write is dropped.
  - eret with we: both apply; eret's EXL/ERL update overrides the written Status bits.
- Reset mid-operation: all state returns to reset values on that edge, and Count restarts from 0.

Decomposition:
- Package cop0_pkg holds:
  - cause_t, status_t, ebase_t; cause_t.exc_code is 5 bits at [6:2].
  - Register-number constants and ExcCode constants (Int=0, AdEL=4, AdES=5, Sys=8, Bp=9, RI=10, CpU=11, Ov=12).
  - Write-mask constants and reset-value constants.
- Sub-module cop0_timer: Count, phase, Compare and TI, with load/clear inputs.

Test Plan:
- Reset, then read 12/0, 15/0, 15/1 -> 32'h0040_0004, PRID, 32'h8000_0000; int_req=0.
- mtc0 Status=32'hFFFF_FFFF -> read back 32'hF040_FF17.
- Write Compare=10, Count=0 -> TI and IP[7] set on the cycle Count reaches 10 (~20 cycles); with IM7=1, IE=1, EXL=ERL=0, int_req=1; writing Compare clears TI.
- exc_valid with code 12, exc_pc=32'h8000_0100, bd=1, BEV=0, EBase base=0 -> exc_vector=32'h8000_0180; EPC=32'h8000_00FC; BD=1; EXL=1. A second exc_valid leaves EPC unchanged.
- Interrupt with IV=1, BEV=1, EXL=0 -> exc_vector=32'hBFC0_0400. Then eret with ERL=1 clears ERL only; a second eret clears EXL.
- Same-cycle exc_valid and mtc0 EPC=32'h1234 -> EPC holds the exception value. Count=32'hFFFF_FFFF -> wraps to 0 two cycles later.
